// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM access arbiter.
// Holds the FSM state codes, RAM access size codes, direction encoding
// and owner codes, plus a helper that folds the reserved size code onto
// a word access.
package ram_arb_pkg;

  // FSM state encoding (also visible on the top-level dbg_state output)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // RAM access size codes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Direction encoding shared by the CPU, the loader and the RAM
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Owner codes as reported on GNT
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  // Size code 11 is reserved and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/access_timer.sv
// Access timeout counter.
// Counts ACCESS cycles while en is high and raises expired once the count
// reaches TMO_CYCLES-1, i.e. during the TMO_CYCLES-th enabled cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (held while the arbiter is not in ACCESS)
//   en         : count enable
//   expired    : count has reached TMO_CYCLES-1 (combinational from the count)
module access_timer #(
  parameter int TMO_CYCLES = 15   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TMO_CYCLES);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TMO_CYCLES - 1));

  // Saturates at the expiry value so the counter can never wrap if the
  // owner of en is slow to react.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one RAM port between the microprogrammed control unit (MFA/MFC)
// and a word-wide loader/debug port (LD_REQ/LD_ACK).
//
// Ports:
//   CLK, CLR                         clock, asynchronous active-low reset
//   MFA, RW_RAM, CPU_ADDR,
//   CPU_WDATA, CPU_SIZE, MFC         control-unit request side
//   LD_REQ, LD_RW, LD_ADDR,
//   LD_WDATA, LD_ACK                 loader request side
//   RDATA, BUS_ERR                   read data / timeout flag, valid with MFC/LD_ACK
//   GNT                              current/last owner (0 CPU, 1 loader)
//   RAM_MFA, RAM_RW, RAM_ADDR,
//   RAM_WDATA, RAM_SIZE,
//   RAM_RDATA, RAM_MFC               RAM port
//   dbg_state                        FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: both requester sides are four-phase. A requester raises its
// request and holds it; the arbiter raises that side's completion and
// holds it until the request drops, then drops it one edge later. The
// RAM side sees RAM_MFA held high for the whole access; RAM_MFC is only
// looked at while RAM_MFA is high.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int TMO_CYCLES = 15   // must be >= 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW_RAM,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [31:0]       CPU_WDATA,
  input  logic [1:0]        CPU_SIZE,
  output logic              MFC,
  input  logic              LD_REQ,
  input  logic              LD_RW,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [31:0]       LD_WDATA,
  output logic              LD_ACK,
  output logic [31:0]       RDATA,
  output logic              BUS_ERR,
  output logic              GNT,
  output logic              RAM_MFA,
  output logic              RAM_RW,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [31:0]       RAM_WDATA,
  output logic [1:0]        RAM_SIZE,
  input  logic [31:0]       RAM_RDATA,
  input  logic              RAM_MFC,
  output logic [1:0]        dbg_state
);

  logic [1:0] state;
  logic       grant_ld;
  logic       owner_req;
  logic       tmo_expired;

  assign dbg_state = state;

  // Loader wins if it is the only requester, or on a tie when the CPU
  // held the port last. GNT resets to the loader so the CPU takes the
  // first tie.
  always_comb begin
    grant_ld  = LD_REQ && (!MFA || (GNT == OWN_CPU));
    owner_req = (GNT == OWN_LD) ? LD_REQ : MFA;
  end

  access_timer #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (CLR),
    .clr    (state != ST_ACCESS),
    .en     (state == ST_ACCESS),
    .expired(tmo_expired)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= ST_IDLE;
      MFC       <= 1'b0;
      LD_ACK    <= 1'b0;
      RDATA     <= '0;
      BUS_ERR   <= 1'b0;
      GNT       <= OWN_LD;
      RAM_MFA   <= 1'b0;
      RAM_RW    <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
      RAM_SIZE  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MFA || LD_REQ) begin
            GNT     <= grant_ld;
            RAM_MFA <= 1'b1;
            state   <= ST_ACCESS;
            if (grant_ld) begin
              RAM_RW    <= LD_RW;
              RAM_ADDR  <= LD_ADDR;
              RAM_WDATA <= LD_WDATA;
              RAM_SIZE  <= SZ_WORD;
            end else begin
              RAM_RW    <= RW_RAM;
              RAM_ADDR  <= CPU_ADDR;
              RAM_WDATA <= CPU_WDATA;
              RAM_SIZE  <= norm_size(CPU_SIZE);
            end
          end
        end

        ST_ACCESS: begin
          // RAM_MFC is tested first so a completion in the last allowed
          // cycle beats the timeout.
          if (RAM_MFC || tmo_expired) begin
            RAM_MFA <= 1'b0;
            state   <= ST_DONE;
            if (GNT == OWN_LD) LD_ACK <= 1'b1;
            else               MFC    <= 1'b1;
            if (RAM_MFC) begin
              BUS_ERR <= 1'b0;
              if (RAM_RW == RW_READ) RDATA <= RAM_RDATA;
            end else begin
              // A timed-out access returns zero data regardless of
              // direction so stale data is never mistaken for a result.
              BUS_ERR <= 1'b1;
              RDATA   <= '0;
            end
          end
        end

        ST_DONE: begin
          if (!owner_req) begin
            MFC     <= 1'b0;
            LD_ACK  <= 1'b0;
            BUS_ERR <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed cases, tie
// arbitration, reset abort and randomized traffic against a
// transaction-level reference model with a scoreboard queue.
module tb_ram_access_arbiter;

  localparam int TMO   = 15;
  localparam int NEVER = 1000;

  // ---------------- clock / reset / signals ----------------
  logic        CLK = 1'b0;
  logic        CLR;
  logic        MFA, RW_RAM, LD_REQ, LD_RW, RAM_MFC;
  logic [7:0]  CPU_ADDR, LD_ADDR;
  logic [31:0] CPU_WDATA, LD_WDATA, RAM_RDATA;
  logic [1:0]  CPU_SIZE;
  logic        MFC, LD_ACK, BUS_ERR, GNT, RAM_MFA, RAM_RW;
  logic [31:0] RDATA, RAM_WDATA;
  logic [7:0]  RAM_ADDR;
  logic [1:0]  RAM_SIZE, dbg_state;

  always #5 CLK = ~CLK;

  ram_access_arbiter #(.ADDR_W(8), .TMO_CYCLES(TMO)) dut (
    .CLK(CLK), .CLR(CLR),
    .MFA(MFA), .RW_RAM(RW_RAM), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_SIZE(CPU_SIZE), .MFC(MFC),
    .LD_REQ(LD_REQ), .LD_RW(LD_RW), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_ACK(LD_ACK),
    .RDATA(RDATA), .BUS_ERR(BUS_ERR), .GNT(GNT),
    .RAM_MFA(RAM_MFA), .RAM_RW(RAM_RW), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_SIZE(RAM_SIZE), .RAM_RDATA(RAM_RDATA),
    .RAM_MFC(RAM_MFC), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment ----------------
  // ram_wait = number of ACCESS cycles before RAM_MFC is raised
  logic [31:0] ram_mem[256];
  int          ram_wait = 0;
  int          acc_cnt  = 0;

  always @(negedge CLK) begin
    if (CLR === 1'b1 && RAM_MFA === 1'b1) begin
      if (acc_cnt == ram_wait) begin
        RAM_MFC = 1'b1;
        if (RAM_RW) RAM_RDATA = ram_mem[RAM_ADDR];
        else        ram_mem[RAM_ADDR] = RAM_WDATA;
      end else begin
        RAM_MFC   = 1'b0;
        RAM_RDATA = $urandom;
      end
      acc_cnt++;
    end else begin
      RAM_MFC   = 1'b0;
      RAM_RDATA = $urandom;
      acc_cnt   = 0;
    end
  end

  // ---------------- reference model ----------------
  // Per transaction: error iff the RAM needs TMO or more wait cycles;
  // reads return the model memory, writes keep the previous RDATA,
  // errors return 0. Owner alternates on ties starting with the CPU.
  logic [31:0] ref_mem[256];
  logic [31:0] last_rdata = '0;
  bit          last_owner = 1'b1;
  logic [33:0] exp_q[$];   // {owner, bus_err, rdata}

  task automatic model_txn(input bit ld, input bit rw, input logic [7:0] addr,
                           input logic [31:0] wd, input int w,
                           output int lat, output int mfa_cyc);
    bit          err;
    logic [31:0] rd;
    err = (w >= TMO);
    if (err)     rd = '0;
    else if (rw) rd = ref_mem[addr];
    else         rd = last_rdata;
    if (!err && !rw) ref_mem[addr] = wd;
    last_rdata = rd;
    last_owner = ld;
    exp_q.push_back({ld, err, rd});
    lat     = err ? TMO + 1 : w + 2;
    mfa_cyc = err ? TMO : w + 1;
  endtask

  task automatic model_reset();
    last_rdata = '0;
    last_owner = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_mfc = 1'b0, prev_ack = 1'b0;

  always @(negedge CLK) begin
    logic [33:0] e;
    if (MFC === 1'b1 && LD_ACK === 1'b1) begin
      checks++; errors++;
      $display("FAIL both_completions: MFC=%b LD_ACK=%b expected one-hot at %0t", MFC, LD_ACK, $time);
    end
    if ((MFC === 1'b1 && !prev_mfc) || (LD_ACK === 1'b1 && !prev_ack)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion: MFC=%b LD_ACK=%b with empty queue at %0t", MFC, LD_ACK, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_owner",   64'(LD_ACK),  64'(e[33]));
        check("sb_bus_err", 64'(BUS_ERR), 64'(e[32]));
        check("sb_rdata",   64'(RDATA),   64'(e[31:0]));
      end
    end
    prev_mfc = (MFC === 1'b1);
    prev_ack = (LD_ACK === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input bit ld, input bit rw, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input int w);
    int   lat, mfa_cyc, edges, mfa_seen, hold;
    bit   done, mfa_at1;
    logic [1:0] exp_sz;
    model_txn(ld, rw, addr, wd, w, lat, mfa_cyc);
    exp_sz   = ld ? 2'b10 : ((sz == 2'b11) ? 2'b10 : sz);
    ram_wait = w;
    @(negedge CLK);
    if (ld) begin
      LD_REQ = 1'b1; LD_RW = rw; LD_ADDR = addr; LD_WDATA = wd;
    end else begin
      MFA = 1'b1; RW_RAM = rw; CPU_ADDR = addr; CPU_WDATA = wd; CPU_SIZE = sz;
    end
    edges = 0; mfa_seen = 0; done = 1'b0; mfa_at1 = 1'b0;
    while (!done && edges < 60) begin
      @(posedge CLK); #1;
      edges++;
      if (edges == 1) mfa_at1 = RAM_MFA;
      if (RAM_MFA) mfa_seen++;
      done = ld ? LD_ACK : MFC;
    end
    check("ram_mfa_after_edge1", 64'(mfa_at1), 64'(1));
    check("latency",        64'(edges),    64'(lat));
    check("ram_mfa_cycles", 64'(mfa_seen), 64'(mfa_cyc));
    check("gnt",            64'(GNT),      64'(ld));
    check("ram_size",       64'(RAM_SIZE), 64'(exp_sz));
    check("ram_rw",         64'(RAM_RW),   64'(rw));
    check("ram_addr",       64'(RAM_ADDR), 64'(addr));
    if (!rw) check("ram_wdata", 64'(RAM_WDATA), 64'(wd));
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge CLK); #1;
      check("completion_held", 64'(ld ? LD_ACK : MFC), 64'(1));
    end
    @(negedge CLK);
    if (ld) LD_REQ = 1'b0; else MFA = 1'b0;
    @(posedge CLK); #1;
    check("completion_drop", 64'(ld ? LD_ACK : MFC), 64'(0));
    check("bus_err_clear",   64'(BUS_ERR),           64'(0));
    check("idle_after_drop", 64'(dbg_state),         64'(0));
  endtask

  // Both sides request in the same cycle; only the winner is served and
  // both withdraw together afterwards.
  task automatic tie_once();
    bit   win;
    int   lat, mfa_cyc, edges;
    bit   done;
    logic [7:0] a_cpu, a_ld;
    win   = ~last_owner;
    a_cpu = 8'($urandom_range(0, 127));
    a_ld  = 8'($urandom_range(128, 255));
    model_txn(win, 1'b1, win ? a_ld : a_cpu, '0, 0, lat, mfa_cyc);
    ram_wait = 0;
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = 1'b1; CPU_ADDR = a_cpu; CPU_SIZE = 2'b10;
    LD_REQ = 1'b1; LD_RW = 1'b1; LD_ADDR = a_ld;
    edges = 0; done = 1'b0;
    while (!done && edges < 60) begin
      @(posedge CLK); #1;
      edges++;
      done = win ? LD_ACK : MFC;
    end
    check("tie_latency",       64'(edges), 64'(lat));
    check("tie_gnt",           64'(GNT),   64'(win));
    check("tie_loser_no_cmpl", 64'(win ? MFC : LD_ACK), 64'(0));
    @(negedge CLK);
    MFA = 1'b0; LD_REQ = 1'b0;
    @(posedge CLK); #1;
    check("tie_completion_drop", 64'(win ? LD_ACK : MFC), 64'(0));
    @(posedge CLK); #1;
    check("tie_no_second_grant", 64'(RAM_MFA), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          ld, rw;
    logic [1:0]  sz;
    int          r, w;
    bit          done;
    int          edges;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[8'h40] = 32'h1234_5678;
    ref_mem[8'h40] = 32'h1234_5678;

    CLR = 1'b0; MFA = 1'b0; RW_RAM = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0; CPU_SIZE = '0;
    LD_REQ = 1'b0; LD_RW = 1'b0; LD_ADDR = '0; LD_WDATA = '0;
    RAM_MFC = 1'b0; RAM_RDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_state",   64'(dbg_state), 64'(0));
    check("rst_outputs", 64'({MFC, LD_ACK, BUS_ERR, RAM_MFA, RAM_RW}), 64'(0));
    check("rst_rdata",   64'(RDATA),     64'(0));
    check("rst_gnt",     64'(GNT),       64'(1));
    @(negedge CLK);
    CLR = 1'b1;

    // directed: CPU read zero wait, loader write 3 waits
    run_txn(1'b0, 1'b1, 8'h40, 32'h0, 2'b10, 0);
    run_txn(1'b1, 1'b0, 8'h10, 32'hCAFE_F00D, 2'b00, 3);
    // ties: CPU first, then loader
    tie_once();
    tie_once();
    // timeout and last-cycle completion
    run_txn(1'b0, 1'b1, 8'h22, 32'h0, 2'b01, NEVER);
    run_txn(1'b0, 1'b1, 8'h10, 32'h0, 2'b11, TMO - 1);

    // reset mid-ACCESS
    ram_wait = NEVER;
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = 1'b1; CPU_ADDR = 8'h33;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("pre_clr_access", 64'(dbg_state), 64'(1));
    CLR = 1'b0;
    #1;
    check("clr_ram_mfa", 64'(RAM_MFA),   64'(0));
    check("clr_state",   64'(dbg_state), 64'(0));
    check("clr_gnt",     64'(GNT),       64'(1));
    check("clr_rdata",   64'(RDATA),     64'(0));
    MFA = 1'b0;
    model_reset();
    @(negedge CLK);
    CLR = 1'b1;

    // reset while DONE holds MFC
    begin
      int lat, mfa_cyc;
      model_txn(1'b0, 1'b1, 8'h40, '0, 0, lat, mfa_cyc);
    end
    ram_wait = 0;
    @(negedge CLK);
    MFA = 1'b1; RW_RAM = 1'b1; CPU_ADDR = 8'h40;
    edges = 0; done = 1'b0;
    while (!done && edges < 60) begin
      @(posedge CLK); #1;
      edges++;
      done = MFC;
    end
    check("pre_clr_done_mfc", 64'(MFC), 64'(1));
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    check("clr_mfc",    64'(MFC),    64'(0));
    check("clr_ld_ack", 64'(LD_ACK), 64'(0));
    MFA = 1'b0;
    model_reset();
    @(negedge CLK);
    CLR = 1'b1;
    tie_once();   // CPU must win again after reset

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      w  = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? TMO - 1 : (r == 8) ? TMO : NEVER;
      run_txn(ld, rw, 8'($urandom), $urandom, sz, w);
      if ($urandom_range(0, 3) == 0) tie_once();
    end

    repeat (3) @(posedge CLK);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // cycle budget
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
